ram_scan_display: RTL

//  Downstream consumer of the 4x4 switch-driven R/W RAM in top.

---
 rtl/ram_scan_pkg.sv | 23 ++
 rtl/hex7seg.sv | 13 +
 rtl/ram_scan_display.sv | 102 ++++++++++
 3 files changed

// File: rtl/ram_scan_pkg.sv
// Shared definitions for the RAM scan display block.
//   scan_state_t : scanner FSM states (IDLE, ISSUE, WAIT, SHOW)
//   HEX7_TABLE   : 7-segment patterns {g,f,e,d,c,b,a}, active-high, digits 0..F
//   hex7()       : digit -> segment pattern lookup
package ram_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    SHOW  = 2'd3
  } scan_state_t;

  localparam logic [6:0] HEX7_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] hex7(input logic [3:0] digit);
    return HEX7_TABLE[digit];
  endfunction

endpackage

// File: rtl/hex7seg.sv
// Combinational hex digit to 7-segment decoder.
//   digit : 4-bit value to show
//   segs  : {g,f,e,d,c,b,a}, active-high
module hex7seg
  import ram_scan_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] segs
);

  assign segs = hex7(digit);

endmodule

// File: rtl/ram_scan_display.sv
// Sweeps the RAM address space, reads each word and shows it as a hex digit,
// holding each word for DWELL cycles. Never captures read data from a cycle
// in which the RAM is writing; such reads are simply reissued.
//   clk_2    : system clock
//   reset    : synchronous, active-high
//   enable   : allow scanning; when low the block parks after the current word
//   hold     : refresh the same address instead of advancing
//   wr_busy  : RAM is writing this cycle
//   rd_data  : RAM registered read data (one cycle after rd_addr/rd_en)
//   rd_en    : read request, rd_addr meaningful while high
//   rd_addr  : address presented to the RAM
//   cur_addr : address of the displayed word
//   valid    : display holds a successfully read word
//   seg      : {valid, g,f,e,d,c,b,a}
module ram_scan_display
  import ram_scan_pkg::*;
#(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 4,
  parameter int DWELL      = 3
) (
  input  logic                  clk_2,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  hold,
  input  logic                  wr_busy,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [ADDR_WIDTH-1:0] cur_addr,
  output logic                  valid,
  output logic [7:0]            seg
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

  scan_state_t           state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [CNT_W-1:0]      dwell_cnt;
  logic [6:0]            rd_segs;

  // Decode straight from the RAM output so the display register is loaded
  // in the capture cycle, keeping ISSUE -> seg at two cycles.
  hex7seg u_hex7seg (
    .digit (rd_data),
    .segs  (rd_segs)
  );

  // A request is withheld while the RAM writes; the RAM would ignore it.
  assign rd_en   = (state == ISSUE) && !wr_busy;
  assign rd_addr = ptr;

  always_ff @(posedge clk_2) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      cur_addr  <= '0;
      valid     <= 1'b0;
      seg       <= 8'h00;
      dwell_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) state <= ISSUE;
        end
        ISSUE: begin
          if (!wr_busy) state <= WAIT;
        end
        WAIT: begin
          // A write during the data cycle means the word may be stale:
          // drop it and reissue the same address.
          if (!wr_busy) begin
            seg       <= {1'b1, rd_segs};
            cur_addr  <= ptr;
            valid     <= 1'b1;
            dwell_cnt <= DWELL_LAST;
            state     <= SHOW;
          end else begin
            state <= ISSUE;
          end
        end
        SHOW: begin
          if (dwell_cnt == '0) begin
            if (!enable) begin
              state <= IDLE;
            end else if (hold) begin
              state <= ISSUE;
            end else begin
              ptr   <= ptr + 1'b1;
              state <= ISSUE;
            end
          end else begin
            dwell_cnt <= dwell_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
